sync_updown_counter: RTL and testbench
======================================

// Module: sync_updown_counter
// PURPOSE
//  Parametrised synchronous up/down counter: WIDTH bits, programmable modulus, wrap or saturate.
//  All bits share one clock edge; next state comes from a single enable/direction chain.
//  Adds parallel load, synchronous clear and cascade outputs (tc, ovf), so instances chain
//  into wider or multi-digit (e.g. BCD) counters.
// PARAMETERS
//  WIDTH     4               counter width in bits, >= 1
//  MAX_VAL   (2**WIDTH)-1    highest count value; count range is 0..MAX_VAL; MAX_VAL <= 2**WIDTH-1
//  SATURATE  0               0 = wrap at limits; 1 = hold at limits
// PORTS
//  clk       in   1      rising-edge clock
//  reset_n   in   1      asynchronous, active-low reset
//  en        in   1      count enable (T input of stage 0 / cascade carry-in)
//  up_dn     in   1      1 = count up, 0 = count down; sampled every cycle
//  load      in   1      synchronous parallel load strobe
//  load_val  in   WIDTH  value loaded when load=1
//  sync_clr  in   1      synchronous clear to 0
//  q         out  WIDTH  registered count value
//  tc        out  1      terminal count, combinational: en & ((up_dn & q==MAX_VAL) | (!up_dn & q==0))
//  ovf       out  1      registered 1-cycle pulse: limit reached while counting was attempted
// BEHAVIOUR
//  Reset: reset_n=0 forces q=0, ovf=0 immediately, independent of clk.
//   Reset is released synchronously to clk by the upstream reset logic.
//   A reset assertion mid-count aborts the count. The first edge after release acts on the inputs.
//  Per-edge priority, highest first:
//   1. sync_clr=1  -> q<=0, ovf<=0
//   2. load=1      -> q<=min(load_val, MAX_VAL), ovf<=0. Out-of-range load_val clamps to MAX_VAL.
//   3. en=1, up_dn=1:
//      - q<MAX_VAL -> q<=q+1
//      - q==MAX_VAL -> q<=0 (SATURATE=0) or q holds (SATURATE=1); ovf<=1
//   4. en=1, up_dn=0:
//      - q>0 -> q<=q-1
//      - q==0 -> q<=MAX_VAL (SATURATE=0) or q holds (SATURATE=1); ovf<=1
//   5. en=0 -> q holds, ovf<=0
//  Latency: q updates 1 cycle after the sampled inputs. tc is valid in the same cycle as q/en/up_dn.
//  ovf is high for exactly one cycle per limit event. In SATURATE=1 with en held at a limit,
//   ovf stays high every cycle.
//  Arithmetic is modulo (MAX_VAL+1). q never exceeds MAX_VAL after any operation.
//  Cascading: drive the next stage's en from this stage's tc, with a shared up_dn.
//   The chain is combinational within one clock, giving a fully synchronous ripple-free counter.
//  Direction change: an up_dn toggle takes effect on the next edge with no dead cycle.
//  X on inputs while reset_n=0 must not propagate to q.
// TESTING
//  T1 WIDTH=4 default MAX_VAL: reset, en=1, up_dn=1 for 17 clks
//     -> q=0,1..15,0,1; tc=1 only when q=15; ovf pulses once after 15->0.
//  T2 MAX_VAL=9 (BCD): en=1 up from 0
//     -> q 0..9,0; ovf 1 cycle after 9->0. Then up_dn=0 from 0 -> q=9, ovf pulse.
//  T3 SATURATE=1, MAX_VAL=9: count up 12 clks
//     -> q stops at 9, ovf high each cycle at limit. Down from 0 holds 0.
//  T4 Priority: q=5, assert sync_clr=1, load=1 (load_val=7), en=1 together -> q=0.
//     Next cycle load=1, load_val=12, MAX_VAL=9 -> q=9.
//  T5 Async reset: assert reset_n=0 mid-cycle at q=6
//     -> q=0 before the next edge. Deassert, en=1 -> q=1 one edge later.
//  T6 Cascade: two 4-bit instances, MAX_VAL=9, tc0->en1, 100 up clks from 0
//     -> {q1,q0} steps 00..99 then 00; single ovf1 pulse.

Source files
------------

// File: rtl/sync_updown_counter.sv
// Synchronous up/down counter with programmable modulus (0..MAX_VAL).
// It can wrap or saturate at the limits, and supports parallel load and synchronous clear.
// The tc/ovf outputs let instances chain into wider or multi-digit counters.
// Cascading: feed the next stage's en from this stage's tc and share up_dn.
module sync_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    // When the modulus fills the whole register, no load value can be out of range.
    localparam bit FULL_RANGE = (MAX_VAL == (1 << WIDTH) - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_q == MAX_Q);
    assign at_zero = (count_q == '0);

    generate
        if (FULL_RANGE) begin : g_no_clamp
            assign load_clamped = load_val;
        end else begin : g_clamp
            assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
        end
    endgenerate

    // Next-state selection: clear > load > count > hold; ovf flags a limit hit while counting.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (sync_clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? count_q : MAX_Q;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers; asynchronous reset keeps X on inputs away from the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Terminal count is combinational so a cascade resolves within one clock.
    assign tc  = en & ((up_dn & at_max) | (~up_dn & at_zero));
    assign q   = count_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: binary wrap, BCD wrap, saturation,
// priority, asynchronous reset and a two-digit BCD cascade.
module tb_sync_updown_counter;

    logic clk;
    logic rst_n;      // shared by dut_b, dut_c and the cascade
    logic rst_a_n;    // dut_a only, used for the async reset step

    int checks = 0;
    int errors = 0;

    // dut_a: WIDTH=4, default MAX_VAL=15, wrap
    logic       a_en, a_up, a_load, a_clr;
    logic [3:0] a_lv, a_q;
    logic       a_tc, a_ovf;

    // dut_b: MAX_VAL=9, wrap
    logic       b_en, b_up, b_load, b_clr;
    logic [3:0] b_lv, b_q;
    logic       b_tc, b_ovf;

    // dut_c: MAX_VAL=9, saturate
    logic       c_en, c_up, c_load, c_clr;
    logic [3:0] c_lv, c_q;
    logic       c_tc, c_ovf;

    // cascade: two MAX_VAL=9 digits
    logic       k_en, k_up;
    logic [3:0] k_q0, k_q1;
    logic       k_tc0, k_tc1, k_ovf0, k_ovf1;

    sync_updown_counter #(.WIDTH(4)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .sync_clr(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
    );

    sync_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset_n(rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .sync_clr(b_clr), .q(b_q), .tc(b_tc), .ovf(b_ovf)
    );

    sync_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_c (
        .clk(clk), .reset_n(rst_n), .en(c_en), .up_dn(c_up), .load(c_load),
        .load_val(c_lv), .sync_clr(c_clr), .q(c_q), .tc(c_tc), .ovf(c_ovf)
    );

    sync_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_k0 (
        .clk(clk), .reset_n(rst_n), .en(k_en), .up_dn(k_up), .load(1'b0),
        .load_val(4'd0), .sync_clr(1'b0), .q(k_q0), .tc(k_tc0), .ovf(k_ovf0)
    );

    sync_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_k1 (
        .clk(clk), .reset_n(rst_n), .en(k_tc0), .up_dn(k_up), .load(1'b0),
        .load_val(4'd0), .sync_clr(1'b0), .q(k_q1), .tc(k_tc1), .ovf(k_ovf1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_a_n = 1'b0;
        a_en = 0; a_up = 0; a_load = 0; a_clr = 0; a_lv = 0;
        b_en = 0; b_up = 0; b_load = 0; b_clr = 0; b_lv = 0;
        c_en = 0; c_up = 0; c_load = 0; c_clr = 0; c_lv = 0;
        k_en = 0; k_up = 0;

        tick();
        tick();
        check("reset_a_q",   a_q,   0);
        check("reset_a_ovf", a_ovf, 0);
        check("reset_b_q",   b_q,   0);
        check("reset_c_ovf", c_ovf, 0);
        check("reset_k_q",   {k_q1, k_q0}, 0);

        // Release resets away from the edge, then enable counting up.
        rst_n   = 1'b1;
        rst_a_n = 1'b1;
        a_en = 1; a_up = 1;
        #1;
        check("t1_tc_at0", a_tc, 0);

        // T1: 4-bit binary wrap, 17 edges
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("t1_q_%0d", k),   a_q,   k % 16);
            check($sformatf("t1_tc_%0d", k),  a_tc,  (k % 16) == 15);
            check($sformatf("t1_ovf_%0d", k), a_ovf, k == 16);
        end

        // T2: BCD wrap up, then down through zero
        b_en = 1; b_up = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t2_q_%0d", k),   b_q,   k % 10);
            check($sformatf("t2_ovf_%0d", k), b_ovf, k == 10);
        end
        b_up = 0;
        #1;
        check("t2_tc_down0", b_tc, 1);
        tick();
        check("t2_down_q",   b_q,   9);
        check("t2_down_ovf", b_ovf, 1);
        tick();
        check("t2_down2_q",   b_q,   8);
        check("t2_down2_ovf", b_ovf, 0);

        // T3: saturating BCD counter
        c_en = 1; c_up = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t3_q_%0d", k),   c_q,   (k > 9) ? 9 : k);
            check($sformatf("t3_ovf_%0d", k), c_ovf, k >= 10);
        end
        c_clr = 1;
        tick();
        check("t3_clr_q",   c_q,   0);
        check("t3_clr_ovf", c_ovf, 0);
        c_clr = 0; c_up = 0;
        tick();
        check("t3_dn_q",   c_q,   0);
        check("t3_dn_ovf", c_ovf, 1);
        tick();
        check("t3_dn2_q",   c_q,   0);
        check("t3_dn2_ovf", c_ovf, 1);
        c_en = 0;
        tick();
        check("t3_idle_ovf", c_ovf, 0);

        // T4: priority and load clamping on the wrapping BCD counter
        b_en = 0; b_load = 1; b_lv = 4'd5;
        tick();
        check("t4_load5", b_q, 5);
        b_clr = 1; b_load = 1; b_lv = 4'd7; b_en = 1; b_up = 1;
        tick();
        check("t4_clr_wins_q",   b_q,   0);
        check("t4_clr_wins_ovf", b_ovf, 0);
        b_clr = 0; b_load = 1; b_lv = 4'd12;
        tick();
        check("t4_clamp", b_q, 9);
        b_lv = 4'd3; b_en = 1;
        tick();
        check("t4_load_over_en", b_q, 3);
        b_load = 0; b_en = 0;
        tick();
        check("t4_hold_q",   b_q,   3);
        check("t4_hold_tc",  b_tc,  0);
        check("t4_hold_ovf", b_ovf, 0);
        b_lv = 4'd9; b_load = 1; b_en = 1; b_up = 1;
        tick();
        check("t4_load_at_max_ovf", b_ovf, 0);
        check("t4_tc_at_max",       b_tc,  1);
        b_load = 0; b_en = 0;

        // T5: asynchronous reset mid-cycle
        a_en = 0; a_load = 1; a_lv = 4'd6;
        tick();
        check("t5_load6", a_q, 6);
        a_load = 0; a_en = 1; a_up = 1;
        @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        check("t5_async_q",   a_q,   0);
        check("t5_async_ovf", a_ovf, 0);
        a_en = 1'bx; a_load = 1'bx; a_lv = 4'bxxxx; a_clr = 1'bx; a_up = 1'bx;
        tick();
        check("t5_x_in_reset", a_q, 0);
        a_en = 1; a_up = 1; a_load = 0; a_clr = 0; a_lv = 4'd0;
        rst_a_n = 1'b1;
        tick();
        check("t5_first_edge", a_q, 1);

        // T6: two-digit BCD cascade, 100 edges up from 00
        k_en = 1; k_up = 1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            check($sformatf("t6_q1_%0d", k),   k_q1,   (k % 100) / 10);
            check($sformatf("t6_q0_%0d", k),   k_q0,   k % 10);
            check($sformatf("t6_ovf1_%0d", k), k_ovf1, k == 100);
            if (k == 99) begin
                check("t6_tc1_at99", k_tc1, 1);
            end
        end
        check("t6_ovf0_at100", k_ovf0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
